// File: rtl/mux_memoria_rr.sv
// rtl/mux_memoria_rr.sv - registered N-channel mux with fixed or round-robin grant
// The output word is held when nothing is granted; hold_cnt counts the stale cycles.
module mux_memoria_rr #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int HOLD_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  input  logic [SEL_W-1:0]          selector,
  input  logic                      mode,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic [HOLD_W-1:0]         hold_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  chan_q, chan_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              fix_hit;
  logic [SEL_W-1:0]  fix_idx;
  logic [WIDTH-1:0]  fix_data;

  logic              rr_hit;
  logic [SEL_W-1:0]  rr_idx;
  logic [SEL_W-1:0]  rr_next;
  logic [WIDTH-1:0]  rr_data;
  int                rr_off;
  int                rr_best;

  logic              grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  grant_data;

  // An out-of-range selector matches no channel, so it never grants.
  always_comb begin
    fix_hit  = 1'b0;
    fix_idx  = '0;
    fix_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (selector == SEL_W'(i) && valid_in[i]) begin
        fix_hit  = 1'b1;
        fix_idx  = SEL_W'(i);
        fix_data = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Each valid channel is ranked by its distance from rr_ptr; the nearest wins.
  always_comb begin
    rr_off  = 0;
    rr_best = CHANNELS;
    rr_idx  = '0;
    rr_next = '0;
    rr_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (valid_in[i]) begin
        if (i >= int'(rr_ptr_q)) begin
          rr_off = i - int'(rr_ptr_q);
        end else begin
          rr_off = i - int'(rr_ptr_q) + CHANNELS;
        end
        if (rr_off < rr_best) begin
          rr_best = rr_off;
          rr_idx  = SEL_W'(i);
          rr_data = data_in[i*WIDTH +: WIDTH];
          rr_next = (i == CHANNELS - 1) ? '0 : SEL_W'(i + 1);
        end
      end
    end
    rr_hit = (rr_best < CHANNELS);
  end

  always_comb begin
    grant      = mode ? rr_hit  : fix_hit;
    grant_idx  = mode ? rr_idx  : fix_idx;
    grant_data = mode ? rr_data : fix_data;
  end

  always_comb begin
    data_d   = data_q;
    chan_d   = chan_q;
    valid_d  = 1'b0;
    hold_d   = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      data_d  = grant_data;
      chan_d  = grant_idx;
      valid_d = 1'b1;
      hold_d  = '0;
    end
    // Fixed-mode grants leave the pointer alone so round-robin resumes where it stopped.
    if (mode && rr_hit) begin
      rr_ptr_d = rr_next;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      chan_q   <= '0;
      hold_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      chan_q   <= chan_d;
      hold_q   <= hold_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign chan_out  = chan_q;
  assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_mux_memoria_rr.sv
// tb/tb_mux_memoria_rr.sv - randomized and directed bench for mux_memoria_rr
module tb_mux_memoria_rr;

  localparam int W    = 2;
  localparam int C    = 4;
  localparam int SW   = 2;
  localparam int HW   = 4;
  localparam int HMAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_L;
  logic [C*W-1:0] data_in;
  logic [C-1:0]   valid_in;
  logic [SW-1:0]  selector;
  logic           mode;
  logic [W-1:0]   data_out;
  logic           valid_out;
  logic [SW-1:0]  chan_out;
  logic [HW-1:0]  hold_cnt;

  logic [3*W-1:0] d3_data_in;
  logic [2:0]     d3_valid_in;
  logic [SW-1:0]  d3_selector;
  logic           d3_mode;
  logic [W-1:0]   d3_data_out;
  logic           d3_valid_out;
  logic [SW-1:0]  d3_chan_out;
  logic [HW-1:0]  d3_hold_cnt;

  mux_memoria_rr #(.WIDTH(W), .CHANNELS(C), .SEL_W(SW), .HOLD_W(HW)) dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .selector(selector), .mode(mode), .data_out(data_out), .valid_out(valid_out),
    .chan_out(chan_out), .hold_cnt(hold_cnt)
  );

  mux_memoria_rr #(.WIDTH(W), .CHANNELS(3), .SEL_W(SW), .HOLD_W(HW)) dut3 (
    .clk(clk), .reset_L(reset_L), .data_in(d3_data_in), .valid_in(d3_valid_in),
    .selector(d3_selector), .mode(d3_mode), .data_out(d3_data_out), .valid_out(d3_valid_out),
    .chan_out(d3_chan_out), .hold_cnt(d3_hold_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference state: what the outputs must be, derived from the grant rules alone.
  logic [W-1:0] m_data;
  logic         m_valid;
  int           m_chan;
  int           m_hold;
  int           m_ptr;

  function automatic int model_grant(input logic md, input logic [SW-1:0] sel,
                                     input logic [C-1:0] v, input int ptr);
    int g = -1;
    if (!md) begin
      if (int'(sel) < C && v[sel]) g = int'(sel);
    end else begin
      for (int k = C - 1; k >= 0; k--) begin
        if (v[2'((ptr + k) % C)]) g = (ptr + k) % C;
      end
    end
    return g;
  endfunction

  function automatic int grant_now();
    return model_grant(mode, selector, valid_in, m_ptr);
  endfunction

  function automatic logic [W-1:0] chan_data(input int g);
    return data_in[3'(g * W) +: W];
  endfunction

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_chan  <= 0;
      m_hold  <= 0;
      m_ptr   <= 0;
    end else if (grant_now() >= 0) begin
      m_data  <= chan_data(grant_now());
      m_chan  <= grant_now();
      m_valid <= 1'b1;
      m_hold  <= 0;
      if (mode) m_ptr <= (grant_now() + 1) % C;
    end else begin
      m_valid <= 1'b0;
      m_hold  <= (m_hold < HMAX) ? m_hold + 1 : HMAX;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model data_out", int'(data_out), int'(m_data));
      chk("model valid_out", int'(valid_out), int'(m_valid));
      chk("model chan_out", int'(chan_out), m_chan);
      chk("model hold_cnt", int'(hold_cnt), m_hold);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  int idle;
  int exp_rr[3];

  initial begin
    reset_L = 1'b0; mode = 1'b0; selector = '0; valid_in = '0; data_in = '0;
    d3_data_in = '0; d3_valid_in = '0; d3_selector = '0; d3_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Load a nonzero output, then reset between edges.
    reset_L = 1'b1; data_in = '1; valid_in = '1; selector = 2'd1;
    @(negedge clk);
    chk("pre-reset chan_out", int'(chan_out), 1);
    #2 reset_L = 1'b0;
    #1;
    chk("async reset data_out", int'(data_out), 0);
    chk("async reset valid_out", int'(valid_out), 0);
    chk("async reset chan_out", int'(chan_out), 0);
    chk("async reset hold_cnt", int'(hold_cnt), 0);
    @(negedge clk);
    reset_L = 1'b1; mode = 1'b0; selector = 2'd2;
    @(negedge clk);
    chk("first grant data_out", int'(data_out), 3);
    chk("first grant chan_out", int'(chan_out), 2);

    // Fixed mode, then memory while idle.
    selector = 2'd1; valid_in = 4'b0010; data_in = 8'b0000_1000;
    @(negedge clk);
    chk("fixed data_out", int'(data_out), 2);
    chk("fixed valid_out", int'(valid_out), 1);
    valid_in = 4'b0000;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("memory data_out", int'(data_out), 2);
      chk("memory valid_out", int'(valid_out), 0);
      chk("memory hold_cnt", int'(hold_cnt), i);
    end

    // Round-robin fairness with all channels valid.
    mode = 1'b1; valid_in = 4'b1111; data_in = 8'b11_10_01_00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr fair chan_out", int'(chan_out), i % 4);
      chk("rr fair data_out", int'(data_out), i % 4);
    end

    // Pointer lands on 3 after ch2, then skip/wrap over 0101.
    valid_in = 4'b0100;
    @(negedge clk);
    chk("rr ch2 chan_out", int'(chan_out), 2);
    valid_in = 4'b0101;
    exp_rr[0] = 0; exp_rr[1] = 2; exp_rr[2] = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr wrap chan_out", int'(chan_out), exp_rr[i]);
    end

    // Saturation of the stale counter.
    valid_in = 4'b0000;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("sat hold_cnt", int'(hold_cnt), (i < 15) ? i : 15);
    end
    valid_in = 4'b0001;
    @(negedge clk);
    chk("sat release hold_cnt", int'(hold_cnt), 0);
    chk("sat release valid_out", int'(valid_out), 1);
    valid_in = 4'b0000;

    // Three-channel instance: out-of-range selector and pointer preservation.
    d3_data_in = 6'b01_10_11; d3_mode = 1'b1; d3_valid_in = 3'b010;
    @(negedge clk);
    chk("d3 rr chan_out", int'(d3_chan_out), 1);
    chk("d3 rr data_out", int'(d3_data_out), 2);
    d3_mode = 1'b0; d3_selector = 2'd0; d3_valid_in = 3'b111;
    @(negedge clk);
    chk("d3 fixed chan_out", int'(d3_chan_out), 0);
    chk("d3 fixed data_out", int'(d3_data_out), 3);
    d3_selector = 2'd3;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk("d3 oor valid_out", int'(d3_valid_out), 0);
      chk("d3 oor data_out", int'(d3_data_out), 3);
      chk("d3 oor hold_cnt", int'(d3_hold_cnt), i);
    end
    d3_mode = 1'b1;
    @(negedge clk);
    chk("d3 switch chan_out", int'(d3_chan_out), 2);
    chk("d3 switch data_out", int'(d3_data_out), 1);
    @(negedge clk);
    chk("d3 wrap chan_out", int'(d3_chan_out), 0);
    d3_valid_in = '0; d3_mode = 1'b0;

    // Randomized traffic with idle bursts and mid-cycle resets.
    idle = 0;
    for (int n = 0; n < 600; n++) begin
      mode     = 1'($urandom_range(0, 1));
      selector = SW'($urandom);
      data_in  = (C*W)'($urandom);
      valid_in = C'($urandom);
      if (idle == 0 && $urandom_range(0, 40) == 0) idle = 18;
      if (idle > 0) begin
        valid_in = '0;
        idle--;
      end
      if ($urandom_range(0, 70) == 0) begin
        #2 reset_L = 1'b0;
        #1;
        chk("rand reset data_out", int'(data_out), 0);
        chk("rand reset hold_cnt", int'(hold_cnt), 0);
        @(negedge clk);
        reset_L = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_memoria_rr.md
# mux_memoria_rr

Parametrised registered N-channel multiplexer with output memory. It generalises the 2-input, 2-bit registered mux to CHANNELS inputs of WIDTH bits, each with its own valid. Two selection modes: fixed (external selector) and round-robin arbitration. The output register holds its last value when no channel is granted, and a saturating counter reports how long the output has been stale. It sits between parallel data producers and a single downstream consumer in the datapath.

## Interface
- WIDTH, 2, data bits per channel
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, selector/channel-index width; must satisfy 2**SEL_W >= CHANNELS
- HOLD_W, 4, width of the stale-cycle counter
- clk  input  1  single clock; all state updates on its rising edge
- reset_L  input  1  asynchronous, active-low reset
- data_in  input  CHANNELS*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH]
- valid_in  input  CHANNELS  per-channel valid; bit i qualifies channel i
- selector  input  SEL_W  channel chosen in fixed mode
- mode  input  1  0 = fixed selector, 1 = round-robin
- data_out  output  WIDTH  registered data of the last granted channel
- valid_out  output  1  high for one cycle per cycle a new word was latched
- chan_out  output  SEL_W  index of the channel latched into data_out
- hold_cnt  output  HOLD_W  consecutive cycles without a grant, saturating

## Operation
- Reset (reset_L = 0, asynchronous assertion, takes effect without clk): data_out = 0, valid_out = 0, chan_out = 0, hold_cnt = 0, internal rr_ptr = 0. Release is sampled on the next rising edge; the first grant can occur on the first edge with reset_L = 1.
- Grant computation (combinational, registered on the edge):
  - mode = 0: grant = selector if selector < CHANNELS and valid_in[selector] = 1; otherwise no grant. Out-of-range selector is never a grant.
  - mode = 1: scan channels rr_ptr, rr_ptr+1, …, wrapping modulo CHANNELS. Grant the first channel with valid_in = 1. If none is valid, there is no grant.
- On grant g:
  - data_out <= data_in[g]
  - chan_out <= g
  - valid_out <= 1
  - hold_cnt <= 0
- On no grant:
  - data_out and chan_out hold (memory)
  - valid_out <= 0
  - hold_cnt <= hold_cnt + 1, saturating at 2**HOLD_W − 1
- rr_ptr update: only in mode 1 on a grant, rr_ptr <= (g + 1) mod CHANNELS. It wraps from CHANNELS−1 to 0. Grants in mode 0 do not change rr_ptr.
- Mode switch mid-stream: takes effect at the next edge. rr_ptr is preserved across switches.
- No backpressure: the consumer must accept every valid_out pulse.

## Timing
- Latency one cycle: inputs sampled at edge k appear on the outputs after edge k.
- Throughput one word per cycle.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- Reset asserted mid-stream clears every output and rr_ptr immediately, regardless of clk.
- Simultaneous valids in mode 1: exactly one grant per cycle. A channel that stays valid is served within CHANNELS cycles (fairness).

## Test plan
- Reset: drive data_in all ones and all valid_in = 1, then assert reset_L = 0 between edges. data_out = 0, valid_out = 0, chan_out = 0 and hold_cnt = 0 immediately. The first edge after release with mode = 0, selector = 2 gives data_out = 3, chan_out = 2.
- Fixed mode with memory: selector = 1, valid_in = 0010, data_in ch1 = 2'b10, so the next cycle gives data_out = 2, valid_out = 1. Then set valid_in = 0000 for 5 cycles: data_out stays 2, valid_out = 0, and hold_cnt steps 1..5.
- Round-robin fairness: mode = 1, valid_in = 1111, channel i carries value i. Over 8 cycles chan_out is 0,1,2,3,0,1,2,3 and data_out matches chan_out.
- Round-robin skip and wrap: rr_ptr = 3 after a grant of ch2, with valid_in = 0101. The grant order is ch0 then ch2 then ch0.
- Saturation: HOLD_W = 4 with no valid for 20 cycles gives hold_cnt = 15 from cycle 15 onward. A single grant then returns hold_cnt to 0.
- Mode switch and out-of-range selector: use CHANNELS = 3, mode 0, selector = 3, valid_in = 111. There is no grant, valid_out = 0 and data_out holds. Switching to mode 1 grants at rr_ptr, which is unchanged by the mode-0 cycles.
